// File: rtl/lcd_hd44780_responder.sv
// Panel side of an HD44780-style 8-bit E/RS/RW bus: 2x40 DDRAM, address counter and busy flag.
// Define LCD_RESP_READ_EN to enable status and DDRAM read-back on LCD_data.
module lcd_hd44780_responder #(
  parameter int BUSY_CYCLES       = 2000,
  parameter int CLEAR_BUSY_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  inout  wire  [7:0] LCD_data,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_char,
  output logic       busy,
  output logic [6:0] ac,
  output logic       disp_on,
  output logic [7:0] err_cnt,
  output logic [4:0] dbg_state
);
  localparam int CW = $clog2(CLEAR_BUSY_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, EXEC, CLEAR, BUSY} state_t;

  state_t        state;
  logic [1:0]    e_sync, rs_sync, rw_sync;
  logic [7:0]    d_sync0, d_sync1;
  logic          e_last, lat_rs, lat_rw;
  logic [7:0]    lat_data;
  logic          cmd_rs;
  logic [7:0]    cmd_data;
  logic [CW-1:0] busy_cnt;
  logic [6:0]    clr_idx;
  logic [7:0]    ddram [80];
  logic          id, cur_on, blink_on;
  logic          commit, wr_commit, rd_data_commit;
  logic          err_bus, err_addr;
  logic [8:0]    err_sum;

  // AC walks line 0 (0x00-0x27) then line 1 (0x40-0x67) as one 80-entry ring.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    if (up) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
    else    return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
  endfunction

  function automatic logic [6:0] ac_index(input logic [6:0] a);
    return a[6] ? ({1'b0, a[5:0]} + 7'd40) : {1'b0, a[5:0]};
  endfunction

  // Valid/ready contract: a bus transfer is offered by the synced E 1->0 edge; it is
  // taken only in IDLE, otherwise the write is dropped and counted as a protocol error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_sync   <= '0;
      rs_sync  <= '0;
      rw_sync  <= '0;
      d_sync0  <= '0;
      d_sync1  <= '0;
      e_last   <= 1'b0;
      lat_rs   <= 1'b0;
      lat_rw   <= 1'b0;
      lat_data <= '0;
    end else begin
      e_sync  <= {e_sync[0], LCD_E};
      rs_sync <= {rs_sync[0], LCD_RS};
      rw_sync <= {rw_sync[0], LCD_RW};
      d_sync0 <= LCD_data;
      d_sync1 <= d_sync0;
      e_last  <= e_sync[1];
      if (e_sync[1]) begin
        lat_rs   <= rs_sync[1];
        lat_rw   <= rw_sync[1];
        lat_data <= d_sync1;
      end
    end
  end

  assign commit    = e_last & ~e_sync[1];
  assign wr_commit = commit & ~lat_rw;
`ifdef LCD_RESP_READ_EN
  assign rd_data_commit = commit & lat_rw & lat_rs;
`else
  assign rd_data_commit = 1'b0;
`endif

  always_comb begin
    err_bus  = (wr_commit && (state != IDLE || (!lat_rs && lat_data == 8'h00))) ||
               (rd_data_commit && state != IDLE);
    err_addr = (state == EXEC) && !cmd_rs && cmd_data[7] && (cmd_data[5:0] > 6'd39);
    err_sum  = {1'b0, err_cnt} + {8'b0, err_bus} + {8'b0, err_addr};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      busy_cnt <= '0;
      ac       <= '0;
      id       <= 1'b1;
      disp_on  <= 1'b0;
      cur_on   <= 1'b0;
      blink_on <= 1'b0;
      err_cnt  <= '0;
      cmd_rs   <= 1'b0;
      cmd_data <= '0;
      clr_idx  <= '0;
      for (int i = 0; i < 80; i++) ddram[i] <= 8'h20;
    end else begin
      err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
      case (state)
        IDLE: begin
          if (wr_commit && (lat_rs || lat_data != 8'h00)) begin
            busy <= 1'b1;
            if (!lat_rs && lat_data == 8'h01) begin
              state   <= CLEAR;
              clr_idx <= '0;
              ac      <= '0;
              id      <= 1'b1;
            end else begin
              state    <= EXEC;
              cmd_rs   <= lat_rs;
              cmd_data <= lat_data;
            end
          end else if (rd_data_commit) begin
            ac <= ac_step(ac, id);
          end
        end
        EXEC: begin
          state    <= BUSY;
          busy_cnt <= CW'(BUSY_CYCLES - 2);
          if (cmd_rs) begin
            ddram[ac_index(ac)] <= cmd_data;
            ac <= ac_step(ac, id);
          end else begin
            casez (cmd_data)
              8'b1???????: ac <= (cmd_data[5:0] > 6'd39) ? {cmd_data[6], 6'd0} : cmd_data[6:0];
              8'b0001????: if (!cmd_data[3]) ac <= ac_step(ac, cmd_data[2]);
              8'b00001???: {disp_on, cur_on, blink_on} <= cmd_data[2:0];
              8'b000001??: id <= cmd_data[1];
              8'b0000001?: begin
                ac       <= '0;
                busy_cnt <= CW'(CLEAR_BUSY_CYCLES - 2);
              end
              default: ;
            endcase
          end
        end
        CLEAR: begin
          ddram[clr_idx] <= 8'h20;
          if (clr_idx == 7'd79) begin
            if (CLEAR_BUSY_CYCLES <= 80) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state    <= BUSY;
              busy_cnt <= CW'(CLEAR_BUSY_CYCLES - 81);
            end
          end else begin
            clr_idx <= clr_idx + 7'd1;
          end
        end
        BUSY: begin
          if (busy_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            busy_cnt <= busy_cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dbg_char <= 8'h20;
    else          dbg_char <= (dbg_addr < 7'd80) ? ddram[dbg_addr] : 8'h20;
  end

  assign dbg_state = {state, id, cur_on, blink_on};

`ifdef LCD_RESP_READ_EN
  logic [7:0] rd_val;
  assign rd_val   = rs_sync[1] ? ddram[ac_index(ac)] : {busy, ac};
  assign LCD_data = (e_sync[1] && rw_sync[1]) ? rd_val : 8'hzz;
`else
  assign LCD_data = 8'hzz;
`endif

endmodule
